// File: rtl/int_ctrl_pkg.sv
// Shared constants, state encoding and CSR write payload for the interrupt/trap sequencer.
package int_ctrl_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned INT_NUM_DEF     = 8;
  localparam int unsigned TIMER_CAUSE_DEF = 7;
  localparam int unsigned MSTATUS_MIE     = 3;

  // Instruction encodings recognised in execute
  localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [XLEN-1:0] INST_MRET   = 32'h3020_0073;

  // CSR addresses
  localparam logic [XLEN-1:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [XLEN-1:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [XLEN-1:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [XLEN-1:0] CSR_MCAUSE  = 32'h0000_0342;

  // mcause values
  localparam logic [XLEN-1:0] CAUSE_ECALL   = 32'd11;
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [XLEN-1:0] CAUSE_INT_BIT = 32'h8000_0000;
  localparam logic [XLEN-1:0] INT_EXT_BASE  = 32'd16;

  // Interrupt line / redirect strobe levels
  localparam logic INT_ASSERT   = 1'b1;
  localparam logic INT_DEASSERT = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WR_MEPC     = 3'd1,
    S_WR_MCAUSE   = 3'd2,
    S_WR_MSTATUS  = 3'd3,
    S_ASSERT      = 3'd4,
    S_MRET_WR     = 3'd5,
    S_MRET_ASSERT = 3'd6
  } state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } csr_wr_t;

  // Trap entry: MPIE <= MIE, MIE <= 0
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
    return {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
  endfunction

  // mret: MIE <= MPIE, MPIE <= 1
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    return {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the interrupt request lines.
// Ports: req (N request bits) -> valid (any set), idx (lowest set index).
module int_prio_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt and trap sequencer: detects ecall/ebreak/async interrupts/mret,
// writes mepc/mcause/mstatus one CSR per cycle, then redirects the PC.
// Ports: clk/rst (sync, active-high); int_flag_i interrupt levels; inst_i,
// inst_addr_i, jump_flag_i, jump_addr_i from execute; hold_flag_i pipeline busy;
// csr_*_i current CSR values; hold_flag_o stall; we_o/waddr_o/data_o CSR write;
// int_assert_o/int_addr_o one-cycle redirect.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned INT_NUM     = INT_NUM_DEF,
  parameter int unsigned TIMER_CAUSE = TIMER_CAUSE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INT_NUM-1:0] int_flag_i,
  input  logic [XLEN-1:0]    inst_i,
  input  logic [XLEN-1:0]    inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [XLEN-1:0]    jump_addr_i,
  input  logic               hold_flag_i,
  input  logic [XLEN-1:0]    csr_mtvec_i,
  input  logic [XLEN-1:0]    csr_mepc_i,
  input  logic [XLEN-1:0]    csr_mstatus_i,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [XLEN-1:0]    waddr_o,
  output logic [XLEN-1:0]    data_o,
  output logic               int_assert_o,
  output logic [XLEN-1:0]    int_addr_o
);

  localparam int unsigned IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  csr_wr_t           wr_q, wr_d;
  logic              assert_q, assert_d;
  logic [XLEN-1:0]   addr_q, addr_d;

  logic              irq_valid;
  logic [IDX_W-1:0]  irq_idx;
  logic              sync_evt, async_evt, mret_evt;
  logic [XLEN-1:0]   sync_cause, async_cause;

  int_prio_enc #(.N(INT_NUM), .IDX_W(IDX_W)) u_prio (
    .req   (int_flag_i ^ {INT_NUM{INT_DEASSERT}}),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  // Event decode; async entry is deferred while the pipeline is busy
  always_comb begin
    sync_evt    = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
    sync_cause  = (inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
    async_evt   = irq_valid && csr_mstatus_i[MSTATUS_MIE] && !hold_flag_i;
    async_cause = CAUSE_INT_BIT |
                  ((irq_idx == '0) ? XLEN'(TIMER_CAUSE) : (INT_EXT_BASE + XLEN'(irq_idx)));
    mret_evt    = (inst_i == INST_MRET);
  end

  // Stall in the detecting cycle as well as throughout any sequence
  assign hold_flag_o = (state_q != S_IDLE) || sync_evt || async_evt || mret_evt;

  // Next state, latched cause/epc, and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    wr_d     = '0;
    assert_d = INT_DEASSERT;
    addr_d   = '0;

    case (state_q)
      S_IDLE: begin
        // A concurrent interrupt loses to mret; it stays pending as a level
        if (sync_evt) begin
          state_d = S_WR_MEPC;
          cause_d = sync_cause;
          epc_d   = inst_addr_i;
        end else if (mret_evt) begin
          state_d = S_MRET_WR;
        end else if (async_evt) begin
          state_d = S_WR_MEPC;
          cause_d = async_cause;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
        end
      end
      S_WR_MEPC:    state_d = S_WR_MCAUSE;
      S_WR_MCAUSE:  state_d = S_WR_MSTATUS;
      S_WR_MSTATUS: state_d = S_ASSERT;
      S_MRET_WR:    state_d = S_MRET_ASSERT;
      default:      state_d = S_IDLE;
    endcase

    case (state_d)
      S_WR_MEPC:     wr_d = '{we: 1'b1, addr: CSR_MEPC,    data: epc_d};
      S_WR_MCAUSE:   wr_d = '{we: 1'b1, addr: CSR_MCAUSE,  data: cause_d};
      S_WR_MSTATUS:  wr_d = '{we: 1'b1, addr: CSR_MSTATUS, data: trap_mstatus(csr_mstatus_i)};
      S_MRET_WR:     wr_d = '{we: 1'b1, addr: CSR_MSTATUS, data: mret_mstatus(csr_mstatus_i)};
      S_ASSERT: begin
        assert_d = INT_ASSERT;
        addr_d   = csr_mtvec_i;
      end
      S_MRET_ASSERT: begin
        assert_d = INT_ASSERT;
        addr_d   = csr_mepc_i;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      wr_q     <= '0;
      assert_q <= INT_DEASSERT;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      wr_q     <= wr_d;
      assert_q <= assert_d;
      addr_q   <= addr_d;
    end
  end

  assign we_o         = wr_q.we;
  assign waddr_o      = wr_q.addr;
  assign data_o       = wr_q.data;
  assign int_assert_o = assert_q;
  assign int_addr_o   = addr_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: a small CSR model applies the DUT's writes,
// expected writes/redirects are queued when stimulus is driven and popped as
// the DUT produces them.
module tb_int_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] MTVEC  = 32'h0000_0100;

  logic        clk, rst;
  logic [7:0]  int_flag;
  logic [31:0] inst, inst_addr, jump_addr;
  logic        jump_flag, hold_in;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  // CSR model
  logic [31:0] ms, mepc;
  logic        set_en;
  logic [31:0] set_ms, set_mepc;

  typedef struct {
    logic        is_jump;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int seq_start = 0;
  logic prev_hold = 1'b0;
  logic prev_assert = 1'b0;
  logic armed = 1'b0;

  int_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .int_flag_i    (int_flag),
    .inst_i        (inst),
    .inst_addr_i   (inst_addr),
    .jump_flag_i   (jump_flag),
    .jump_addr_i   (jump_addr),
    .hold_flag_i   (hold_in),
    .csr_mtvec_i   (MTVEC),
    .csr_mepc_i    (mepc),
    .csr_mstatus_i (ms),
    .hold_flag_o   (hold_flag_o),
    .we_o          (we_o),
    .waddr_o       (waddr_o),
    .data_o        (data_o),
    .int_assert_o  (int_assert_o),
    .int_addr_o    (int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_trap_ms(input logic [31:0] m);
    return (m & ~32'h88) | (m[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] exp_mret_ms(input logic [31:0] m);
    return (m & ~32'h08) | 32'h80 | (m[7] ? 32'h08 : 32'h0);
  endfunction

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    q.push_back('{1'b0, a, d, 0});
  endtask

  task automatic exp_jmp(input logic [31:0] a, input int lat);
    q.push_back('{1'b1, a, 32'h0, lat});
  endtask

  task automatic exp_trap(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] m);
    exp_wr(32'h341, epc);
    exp_wr(32'h342, cause);
    exp_wr(32'h300, exp_trap_ms(m));
    exp_jmp(MTVEC, 4);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [31:0] i, input logic [31:0] a);
    inst      = i;
    inst_addr = a;
    step();
    inst = NOP;
  endtask

  task automatic set_csr(input logic [31:0] m, input logic [31:0] e);
    set_ms   = m;
    set_mepc = e;
    set_en   = 1'b1;
    step();
    set_en   = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      chk("timeout", 32'(q.size()), 32'h0);
      q.delete();
    end
    step();
  endtask

  // CSR register model fed by the DUT's write port
  always @(posedge clk) begin
    if (set_en) begin
      ms   <= set_ms;
      mepc <= set_mepc;
    end else if (we_o === 1'b1) begin
      if (waddr_o == 32'h300) ms <= data_o;
      if (waddr_o == 32'h341) mepc <= data_o;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor / scoreboard
  always @(negedge clk) begin
    exp_t it;
    if (hold_flag_o === 1'b1 && (!prev_hold || prev_assert)) seq_start = cyc;
    if (q.size() != 0) chk("hold", 32'(hold_flag_o), 32'h1);
    if (we_o === 1'b1 || int_assert_o === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious", {30'h0, we_o, int_assert_o}, 32'h0);
      end else begin
        it = q.pop_front();
        chk("kind", 32'(int_assert_o), 32'(it.is_jump));
        if (it.is_jump) begin
          chk("redirect", int_addr_o, it.addr);
          chk("latency", 32'(cyc - seq_start), 32'(it.lat));
        end else begin
          chk("waddr", waddr_o, it.addr);
          chk("wdata", data_o, it.data);
        end
      end
    end
    if (armed && we_o === 1'b0) chk("idle_bus", waddr_o | data_o, 32'h0);
    if (armed && int_assert_o === 1'b0) chk("idle_addr", int_addr_o, 32'h0);
    prev_hold   = hold_flag_o;
    prev_assert = int_assert_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; int_flag = '0; inst = NOP; inst_addr = '0;
    jump_flag = 1'b0; jump_addr = '0; hold_in = 1'b0;
    set_en = 1'b0; set_ms = '0; set_mepc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold",   32'(hold_flag_o),  32'h0);
    chk("rst_we",     32'(we_o),         32'h0);
    chk("rst_waddr",  waddr_o,           32'h0);
    chk("rst_data",   data_o,            32'h0);
    chk("rst_assert", 32'(int_assert_o), 32'h0);
    chk("rst_addr",   int_addr_o,        32'h0);
    step();
    rst   = 1'b0;
    armed = 1'b1;

    // Timer interrupt with MIE = 1
    set_csr(32'h8, 32'h0);
    exp_trap(32'h2C, 32'h8000_0007, ms);
    inst_addr = 32'h2C;
    int_flag  = 8'h01;
    wait_done();
    int_flag = '0;

    // ECALL and EBREAK with MIE = 0
    exp_trap(32'h40, 32'd11, ms);
    fire(ECALL, 32'h40);
    wait_done();
    exp_trap(32'h48, 32'd3, ms);
    fire(EBREAK, 32'h48);
    wait_done();

    // MRET with MPIE = 1
    set_csr(32'h80, 32'h44);
    exp_wr(32'h300, exp_mret_ms(ms));
    exp_jmp(32'h44, 2);
    fire(MRET, 32'h44);
    wait_done();

    // Lines 1 and 2 pending during a jump: line 1 wins, epc is the jump target
    exp_trap(32'h80, 32'h8000_0011, ms);
    int_flag = 8'b0000_0110; jump_flag = 1'b1; jump_addr = 32'h80; inst_addr = 32'h30;
    step();
    jump_flag = 1'b0;
    wait_done();
    int_flag = '0;

    // Same request deferred while the pipeline is busy
    set_csr(32'h88, mepc);
    hold_in = 1'b1; int_flag = 8'b0000_0110; jump_flag = 1'b1; jump_addr = 32'h90;
    repeat (5) step();
    chk("deferred_hold", 32'(hold_flag_o), 32'h0);
    exp_trap(32'h90, 32'h8000_0011, ms);
    hold_in = 1'b0;
    step();
    jump_flag = 1'b0;
    wait_done();
    int_flag = '0;

    // ECALL concurrent with timer: ecall first, timer taken after mret
    set_csr(32'h88, mepc);
    exp_trap(32'h50, 32'd11, ms);
    int_flag = 8'h01;
    fire(ECALL, 32'h50);
    wait_done();
    repeat (3) step();
    exp_wr(32'h300, exp_mret_ms(ms));
    exp_jmp(mepc, 2);
    exp_trap(32'h60, 32'h8000_0007, 32'h88);
    fire(MRET, 32'h60);
    wait_done();
    int_flag = '0;

    // Reset in WR_MCAUSE, then a fresh interrupt
    set_csr(32'h88, mepc);
    exp_trap(32'h2C, 32'h8000_0007, ms);
    inst_addr = 32'h2C;
    int_flag  = 8'h01;
    step();
    step();
    rst = 1'b1; int_flag = '0;
    step();
    q.delete();
    @(negedge clk);
    chk("mid_rst_hold",   32'(hold_flag_o),  32'h0);
    chk("mid_rst_we",     32'(we_o),         32'h0);
    chk("mid_rst_waddr",  waddr_o,           32'h0);
    chk("mid_rst_data",   data_o,            32'h0);
    chk("mid_rst_assert", 32'(int_assert_o), 32'h0);
    chk("mid_rst_addr",   int_addr_o,        32'h0);
    step();
    rst = 1'b0;
    step();
    exp_trap(32'h2C, 32'h8000_0007, ms);
    int_flag = 8'h01;
    wait_done();
    int_flag = '0;

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
